// File: rtl/isr_ctx.sv
// -----------------------------------------------------------------------------
// isr_ctx -- interrupt entry/return context unit (CPU side).
//
// Redirects the program counter to the interrupt subroutine address, saves
// the return address and ALU flags on a small LIFO, and restores them on a
// return-from-interrupt. Each return (or tail-chain) raises a one-cycle `fin`
// pulse that releases the interrupt manager for its next request.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low; clears all state
//   s_interrup     interrupt request from the manager (accepted while high)
//   dir   [AW]     subroutine address, valid with s_interrup
//   pc    [AW]     next-PC the CPU would load this edge (return address)
//   flags_in [FW]  current ALU flags
//   reti           return-from-interrupt executing this cycle
//   pc_sel         1 = CPU loads pc_ovr instead of pc (combinational)
//   pc_ovr [AW]    override PC (combinational)
//   flags_restore  1 = CPU loads flags_out into its flag register (comb.)
//   flags_out [FW] flags to restore (combinational)
//   fin            registered one-cycle end-of-interrupt pulse
//   in_isr         registered; 1 while the stack holds any context
//   depth          current stack occupancy
//   err_ovf        sticky; an entry was refused because the stack was full
//   err_unf        sticky; reti was seen with an empty stack
// -----------------------------------------------------------------------------
module isr_ctx #(
  parameter int AW    = 10,
  parameter int FW    = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_interrup,
  input  logic [AW-1:0]            dir,
  input  logic [AW-1:0]            pc,
  input  logic [FW-1:0]            flags_in,
  input  logic                     reti,
  output logic                     pc_sel,
  output logic [AW-1:0]            pc_ovr,
  output logic                     flags_restore,
  output logic [FW-1:0]            flags_out,
  output logic                     fin,
  output logic                     in_isr,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     err_ovf,
  output logic                     err_unf
);

  localparam int IW = $clog2(DEPTH);
  localparam int DW = IW + 1;
  localparam int EW = AW + FW;

  // Entry layout: {return address, flags}.
  logic [EW-1:0] stack_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          in_isr_q, fin_q, err_ovf_q, err_unf_q;

  logic          full, empty;
  logic [IW-1:0] top_idx;
  logic [EW-1:0] top;
  logic          do_push, do_pop, do_tail, do_ovf, do_unf;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // leaves a value unassigned, which would infer a latch.
    full          = (depth_q == DW'(DEPTH));
    empty         = (depth_q == '0);
    // At depth==DEPTH the low bits wrap to 0, so minus one still lands on
    // the last entry.
    top_idx       = depth_q[IW-1:0] - IW'(1);
    top           = stack_q[top_idx];

    // All decisions are gated by reset so the combinational outputs read 0
    // while reset is held, whatever the request inputs do.
    do_push       = reset &  s_interrup & (~reti | empty) & ~full;
    do_pop        = reset & ~s_interrup &  reti & ~empty;
    do_tail       = reset &  s_interrup &  reti & ~empty;
    do_ovf        = reset &  s_interrup & ~reti &  full;
    do_unf        = reset &  reti & empty;

    pc_sel        = do_push | do_pop | do_tail;
    pc_ovr        = '0;
    flags_restore = do_pop;
    flags_out     = '0;
    if (do_pop) begin
      pc_ovr    = top[EW-1:FW];
      flags_out = top[FW-1:0];
    end else if (do_push || do_tail) begin
      // A tail-chained subroutine inherits the pending return context, so
      // the stack is left untouched.
      pc_ovr = dir;
    end

    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + DW'(1);
    else if (do_pop) depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the stack array is reset as well, because a cleared context
      // store is part of the defined post-reset state, not just the pointer.
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      depth_q   <= '0;
      in_isr_q  <= 1'b0;
      fin_q     <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (do_push) stack_q[depth_q[IW-1:0]] <= {pc, flags_in};
      depth_q  <= depth_d;
      in_isr_q <= (depth_d != '0);
      fin_q    <= do_pop | do_tail;
      if (do_ovf) err_ovf_q <= 1'b1;
      if (do_unf) err_unf_q <= 1'b1;
    end
  end

  assign depth   = depth_q;
  assign in_isr  = in_isr_q;
  assign fin     = fin_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: doc/isr_ctx.md
# isr_ctx

Interrupt entry/return context unit on the CPU side of the interrupt manager. It consumes the manager's `s_interrup` request and 10-bit subroutine address `dir`, and redirects the program counter to that subroutine. On entry it saves the return address and ALU flags on a small LIFO. On a return-from-interrupt instruction it restores both and sends the one-cycle `fin` pulse that releases the manager for the next request.

## Interface
Parameters:
- `AW`, 10: program-counter / subroutine-address width.
- `FW`, 2: saved flag width (zero, carry).
- `DEPTH`, 4: context stack entries (power of two, ≥2).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `s_interrup` input 1: interrupt request from the manager; accepted in the cycle it is high.
- `dir` input AW: subroutine address; valid while `s_interrup`=1.
- `pc` input AW: next-PC value the CPU would load at this edge (the return address).
- `flags_in` input FW: current ALU flags.
- `reti` input 1: decoded return-from-interrupt instruction executing this cycle.
- `pc_sel` output 1: 1 = CPU loads `pc_ovr` instead of `pc` at this edge (combinational).
- `pc_ovr` output AW: override PC (combinational).
- `flags_restore` output 1: 1 = CPU loads `flags_out` into its flag register at this edge (combinational).
- `flags_out` output FW: flags to restore.
- `fin` output 1: registered one-cycle end-of-interrupt pulse to the manager.
- `in_isr` output 1: registered; 1 while stack depth > 0.
- `depth` output $clog2(DEPTH)+1: current stack occupancy.
- `err_ovf` output 1: sticky; an entry was refused because the stack was full.
- `err_unf` output 1: sticky; `reti` was seen with an empty stack.

## Operation
- Stack entry = {return address AW, flags FW}. The stack is a register array indexed by `depth`. `in_isr` = (`depth` != 0).
- Decision per cycle, with E = `s_interrup` and R = `reti`:
  - E=1, R=0, depth<DEPTH (entry): `pc_sel`=1, `pc_ovr`=`dir`. At the edge, push {`pc`, `flags_in`} and increment depth.
  - E=1, R=0, depth=DEPTH (overflow): outputs idle (`pc_sel`=0). Set `err_ovf`. Stack unchanged.
  - E=0, R=1, depth>0 (return): `pc_sel`=1, `pc_ovr`=top.addr, `flags_restore`=1, `flags_out`=top.flags. At the edge, pop, decrement depth, and set `fin` for the next cycle.
  - E=0, R=1, depth=0 (underflow): outputs idle. Set `err_unf`. `fin` stays 0.
  - E=1, R=1, depth>0 (tail-chain): `pc_sel`=1, `pc_ovr`=`dir`, `flags_restore`=0. Stack and depth unchanged. `fin` is pulsed next cycle. The new subroutine inherits the pending return context.
  - E=1, R=1, depth=0: `reti` is the underflow case (`err_unf` set). The request is handled as a normal entry.
  - E=0, R=0: `pc_sel`=0, `flags_restore`=0, `pc_ovr`=0, `flags_out`=0.
- Request priority among ports is resolved upstream in the manager. This block never reorders requests.
- Once set, `err_ovf` and `err_unf` are cleared only by reset.

## Timing
- Entry and return redirects are zero-latency, combinational from `s_interrup`/`reti`. The first subroutine instruction executes in the cycle after the request.
- The stack push/pop and depth update take effect at the same rising edge that loads the new PC.
- `fin` is high for exactly one cycle: the cycle after the return (or tail-chain) edge. It never stays high for two consecutive cycles unless two consecutive returns occur.
- Back-to-back returns in consecutive cycles each pop one entry and each produce a `fin` pulse.
- Reset (async assert, any time, including mid-ISR):
  - depth=0, `in_isr`=0, `fin`=0, `err_ovf`=0, `err_unf`=0, all stack entries 0.
  - Combinational outputs are 0 while reset is held.
  - The first edge after reset release behaves as idle with an empty stack.

## Test plan
- Entry/return: `pc`=17, `flags_in`=2'b01, `s_interrup`=1, `dir`=824 → same cycle `pc_sel`=1, `pc_ovr`=824; then depth=1, `in_isr`=1. Later `reti`=1 → `pc_ovr`=17, `flags_restore`=1, `flags_out`=01; next cycle `fin`=1 for one cycle, depth=0, `in_isr`=0.
- Nesting to full: four entries with `dir`=824/874/924/974 and `pc`=5/6/7/8 → depth=4. A fifth request → `pc_sel`=0, `err_ovf`=1. Four `reti` → `pc_ovr` sequence 8, 7, 6, 5, with four `fin` pulses.
- Tail-chain: depth=1 holding return 40; `s_interrup`=1, `dir`=924 and `reti`=1 together → `pc_ovr`=924, `flags_restore`=0, depth stays 1, `fin` pulses. A later `reti` → `pc_ovr`=40.
- Underflow: depth=0, `reti`=1 → `pc_sel`=0, `err_unf`=1, no `fin`. The bit stays set across later normal traffic.
- Reset mid-ISR: depth=2, pull `reset` low between edges → depth, `in_isr`, `fin` and error bits read 0 immediately. After release, `reti` → underflow behaviour.
